fpu_issue_ctrl: RTL and testbench
=================================

FPU_ISSUE_CTRL -- requirements
Module: fpu_issue_ctrl

Interface
REQ-001 SHALL provide parameter ALU_LAT, default 1, ALU cycles from strobe to valid result (legal 1..15).
REQ-002 SHALL provide parameter W, default 32, operand/result width.
REQ-003 SHALL use one clock and a synchronous, active-low reset: clk  in  1  rising-edge clock.
REQ-004 rst_n  in  1  synchronous active-low reset.
REQ-005 req_valid  in  1  request offered.
REQ-006 req_ready  out  1  request accepted when high with req_valid.
REQ-007 req_op  in  4  0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 INV, 5 ABS, 6 COM; 7-15 illegal.
REQ-008 req_br  in  2  00 none, 01 BLT, 10 BEQ, 11 BGT; meaningful only with COM.
REQ-009 req_a, req_b  in  W  operands.
REQ-010 rsp_valid  out  1  response held until rsp_ready.
REQ-011 rsp_ready  in  1  response consumer ready.
REQ-012 rsp_result  out  W  captured ALU result.
REQ-013 rsp_taken  out  1  captured alu_com_result when req_br != 00, else 0.
REQ-014 rsp_illegal  out  1  op code 7-15.
REQ-015 alu_operand1, alu_operand2  out  W  to ALU.
REQ-016 alu_op_oh  out  10  one-hot strobes [0]ADD [1]SUB [2]MUL [3]DIV [4]INV [5]ABS [6]COM [7]BLT [8]BEQ [9]BGT.
REQ-017 alu_result  in  W; alu_com_result  in  1; alu_flags  in  6  [5]DIVZ [4]QNAN [3]SNAN [2]INEX [1]UNFL [0]OVFL.
REQ-018 fcsr_flags  out  6  sticky exception flags, same bit order; fcsr_clr  in  1  clear sticky flags.

Function
REQ-019 SHALL implement FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
REQ-020 IDLE: req_ready=1; on req_valid latch op, br, a, b and go ISSUE; all other states req_ready=0.
REQ-021 ISSUE (1 cycle): assert op strobe; for COM with br!=00 also assert BLT/BEQ/BGT bit; load wait counter with ALU_LAT; go WAIT.
REQ-022 Strobes and alu_operand1/2 SHALL stay stable from ISSUE through last WAIT cycle, then drop to 0.
REQ-023 WAIT: decrement counter each cycle; at count 1 capture alu_result, rsp_taken, alu_flags; go RESP.
REQ-024 Latency: accept at edge ending cycle N -> rsp_valid first high in cycle N+2+ALU_LAT.
REQ-025 RESP: rsp_valid=1, outputs stable; on rsp_ready go IDLE; next request accepted no earlier than following cycle.
REQ-026 Illegal op: no strobe, no WAIT; ISSUE goes directly to RESP with rsp_result=0, rsp_taken=0, rsp_illegal=1, fcsr_flags unchanged.
REQ-027 req_br with non-COM op SHALL be ignored (no branch strobe, rsp_taken=0).
REQ-028 At capture fcsr_flags <= fcsr_flags | alu_flags.
REQ-029 fcsr_clr alone clears fcsr_flags next edge; fcsr_clr coincident with capture yields fcsr_flags = alu_flags.
REQ-030 alu_op_oh SHALL never have more than one op bit [6:0] set nor any branch bit without bit 6.

Reset
REQ-031 rst_n low at a clk edge SHALL force IDLE, discard any in-flight transaction, zero counter.
REQ-032 Reset values: req_ready=1 after release, rsp_valid=0, rsp_result=0, rsp_taken=0, rsp_illegal=0, alu_op_oh=0, alu_operand1/2=0, fcsr_flags=0.

Structure
REQ-033 Shared package SHALL hold op codes, branch codes, flag bit indices, alu_op_oh bit indices, FSM state encoding.
REQ-034 Single module; no sub-modules; counter width 4 bits.

Verification
REQ-035 ADD a=3, b=4, ALU_LAT=1, ALU returns 7, flags 0 -> strobe bit0 in ISSUE+WAIT, rsp_valid at N+3, rsp_result=7.
REQ-036 COM a=1, b=2, br=01, alu_com_result=1 -> alu_op_oh=0x0C0, rsp_taken=1.
REQ-037 DIV with alu_flags=6'b100000 then MUL with 6'b000100 -> fcsr_flags=6'b100100; fcsr_clr -> 0.
REQ-038 req_op=9 -> alu_op_oh stays 0, rsp_valid at N+2, rsp_illegal=1, rsp_result=0.
REQ-039 rsp_ready held low 5 cycles -> rsp_valid and rsp_result stable, req_ready=0; fcsr_clr coincident with capture of flags 6'b000001 -> fcsr_flags=6'b000001.
REQ-040 rst_n low during WAIT (ALU_LAT=3) -> next cycle IDLE, alu_op_oh=0, no response ever issued.

Source files
------------

// File: rtl/fpu_issue_ctrl_pkg.sv
// Shared definitions for the FPU issue controller: op/branch codes, flag and
// strobe bit positions, FSM state encoding and the op-to-strobe decoder.
package fpu_issue_ctrl_pkg;

  // Request op codes; anything above OpCom is illegal.
  localparam logic [3:0] OpAdd = 4'd0;
  localparam logic [3:0] OpSub = 4'd1;
  localparam logic [3:0] OpMul = 4'd2;
  localparam logic [3:0] OpDiv = 4'd3;
  localparam logic [3:0] OpInv = 4'd4;
  localparam logic [3:0] OpAbs = 4'd5;
  localparam logic [3:0] OpCom = 4'd6;

  // Branch qualifiers, meaningful only with OpCom.
  localparam logic [1:0] BrNone = 2'b00;
  localparam logic [1:0] BrBlt  = 2'b01;
  localparam logic [1:0] BrBeq  = 2'b10;
  localparam logic [1:0] BrBgt  = 2'b11;

  // Exception flag bit positions (alu_flags and fcsr_flags).
  localparam int unsigned FlagWidth = 6;
  localparam int unsigned FlagOvfl  = 0;
  localparam int unsigned FlagUnfl  = 1;
  localparam int unsigned FlagInex  = 2;
  localparam int unsigned FlagSnan  = 3;
  localparam int unsigned FlagQnan  = 4;
  localparam int unsigned FlagDivz  = 5;

  // alu_op_oh bit positions.
  localparam int unsigned OhWidth = 10;
  localparam int unsigned OhAdd   = 0;
  localparam int unsigned OhSub   = 1;
  localparam int unsigned OhMul   = 2;
  localparam int unsigned OhDiv   = 3;
  localparam int unsigned OhInv   = 4;
  localparam int unsigned OhAbs   = 5;
  localparam int unsigned OhCom   = 6;
  localparam int unsigned OhBlt   = 7;
  localparam int unsigned OhBeq   = 8;
  localparam int unsigned OhBgt   = 9;

  localparam int unsigned CntWidth = 4;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2,
    StResp  = 2'd3
  } state_e;

  function automatic logic op_legal(input logic [3:0] op);
    return op <= OpCom;
  endfunction

  // One op strobe; branch strobe only alongside COM. Illegal ops decode to 0.
  function automatic logic [OhWidth-1:0] op_decode(input logic [3:0] op, input logic [1:0] br);
    logic [OhWidth-1:0] oh;
    oh = '0;
    case (op)
      OpAdd:   oh[OhAdd] = 1'b1;
      OpSub:   oh[OhSub] = 1'b1;
      OpMul:   oh[OhMul] = 1'b1;
      OpDiv:   oh[OhDiv] = 1'b1;
      OpInv:   oh[OhInv] = 1'b1;
      OpAbs:   oh[OhAbs] = 1'b1;
      OpCom: begin
        oh[OhCom] = 1'b1;
        case (br)
          BrBlt:   oh[OhBlt] = 1'b1;
          BrBeq:   oh[OhBeq] = 1'b1;
          BrBgt:   oh[OhBgt] = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/fpu_issue_ctrl.sv
// FPU issue controller: accepts one request, drives ALU strobes/operands for
// ALU_LAT cycles, captures the result and holds it until the consumer takes it.
module fpu_issue_ctrl
  import fpu_issue_ctrl_pkg::*;
#(
  parameter int unsigned ALU_LAT = 1,
  parameter int unsigned W       = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [3:0]           req_op,
  input  logic [1:0]           req_br,
  input  logic [W-1:0]         req_a,
  input  logic [W-1:0]         req_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [W-1:0]         rsp_result,
  output logic                 rsp_taken,
  output logic                 rsp_illegal,
  output logic [W-1:0]         alu_operand1,
  output logic [W-1:0]         alu_operand2,
  output logic [OhWidth-1:0]   alu_op_oh,
  input  logic [W-1:0]         alu_result,
  input  logic                 alu_com_result,
  input  logic [FlagWidth-1:0] alu_flags,
  output logic [FlagWidth-1:0] fcsr_flags,
  input  logic                 fcsr_clr
);

  state_e                 state_q, state_d;
  logic [3:0]             op_q, op_d;
  logic [1:0]             br_q, br_d;
  logic [W-1:0]           a_q, a_d;
  logic [W-1:0]           b_q, b_d;
  logic [CntWidth-1:0]    cnt_q, cnt_d;
  logic [W-1:0]           rsp_result_q, rsp_result_d;
  logic                   rsp_taken_q, rsp_taken_d;
  logic                   rsp_illegal_q, rsp_illegal_d;
  logic [FlagWidth-1:0]   fcsr_q, fcsr_d;
  logic                   capture;
  logic                   drive_alu;

  // Next-state: FSM sequencing, request latch, wait counter and result capture.
  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    br_d          = br_q;
    a_d           = a_q;
    b_d           = b_q;
    cnt_d         = cnt_q;
    rsp_result_d  = rsp_result_q;
    rsp_taken_d   = rsp_taken_q;
    rsp_illegal_d = rsp_illegal_q;
    capture       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          op_d    = req_op;
          br_d    = req_br;
          a_d     = req_a;
          b_d     = req_b;
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (!op_legal(op_q)) begin
          rsp_result_d  = '0;
          rsp_taken_d   = 1'b0;
          rsp_illegal_d = 1'b1;
          state_d       = StResp;
        end else begin
          cnt_d   = CntWidth'(ALU_LAT);
          state_d = StWait;
        end
      end
      StWait: begin
        cnt_d = cnt_q - 1'b1;
        // <= 1 rather than == 1 so a zero count can never strand the FSM.
        if (cnt_q <= CntWidth'(1)) begin
          capture       = 1'b1;
          cnt_d         = '0;
          rsp_result_d  = alu_result;
          rsp_taken_d   = (op_q == OpCom) && (br_q != BrNone) && alu_com_result;
          rsp_illegal_d = 1'b0;
          state_d       = StResp;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Sticky flags: clear wins over history but not over the flags being captured.
  always_comb begin
    fcsr_d = fcsr_q;
    if (capture) begin
      fcsr_d = (fcsr_clr ? '0 : fcsr_q) | alu_flags;
    end else if (fcsr_clr) begin
      fcsr_d = '0;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      op_q          <= '0;
      br_q          <= '0;
      a_q           <= '0;
      b_q           <= '0;
      cnt_q         <= '0;
      rsp_result_q  <= '0;
      rsp_taken_q   <= 1'b0;
      rsp_illegal_q <= 1'b0;
      fcsr_q        <= '0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      br_q          <= br_d;
      a_q           <= a_d;
      b_q           <= b_d;
      cnt_q         <= cnt_d;
      rsp_result_q  <= rsp_result_d;
      rsp_taken_q   <= rsp_taken_d;
      rsp_illegal_q <= rsp_illegal_d;
      fcsr_q        <= fcsr_d;
    end
  end

  // ALU drive is held from ISSUE through the last WAIT cycle; illegal ops never reach the ALU.
  always_comb begin
    drive_alu    = ((state_q == StIssue) || (state_q == StWait)) && op_legal(op_q);
    alu_op_oh    = drive_alu ? op_decode(op_q, br_q) : '0;
    alu_operand1 = drive_alu ? a_q : '0;
    alu_operand2 = drive_alu ? b_q : '0;
    req_ready    = (state_q == StIdle);
    rsp_valid    = (state_q == StResp);
    rsp_result   = rsp_result_q;
    rsp_taken    = rsp_taken_q;
    rsp_illegal  = rsp_illegal_q;
    fcsr_flags   = fcsr_q;
  end

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Self-checking bench for fpu_issue_ctrl: directed vector table and randomized
// transactions on an ALU_LAT=1 instance, latency/reset-in-flight on ALU_LAT=3.
module tb_fpu_issue_ctrl;

  localparam int unsigned LatA = 1;
  localparam int unsigned LatB = 3;

  typedef struct {
    logic [3:0]  op;
    logic [1:0]  br;
    logic [31:0] a;
    logic [31:0] b;
    logic [5:0]  flags;
    int          hold;
    bit          clr_cap;
    bit          pre_clr;
    logic [31:0] exp_res;
    bit          exp_taken;
    bit          exp_ill;
    logic [9:0]  exp_oh;
    logic [5:0]  exp_fcsr;
  } vec_t;

  int checks   = 0;
  int failures = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A signals
  logic        rst_n, req_valid, req_ready, rsp_valid, rsp_ready, rsp_taken, rsp_illegal;
  logic [3:0]  req_op;
  logic [1:0]  req_br;
  logic [31:0] req_a, req_b, rsp_result, alu_operand1, alu_operand2, alu_result;
  logic [9:0]  alu_op_oh;
  logic        alu_com_result, fcsr_clr;
  logic [5:0]  alu_flags, fcsr_flags;

  // Instance B signals
  logic        rst_n_b, req_valid_b, req_ready_b, rsp_valid_b, rsp_ready_b;
  logic        rsp_taken_b, rsp_illegal_b;
  logic [31:0] rsp_result_b, alu_operand1_b, alu_operand2_b, alu_result_b;
  logic [9:0]  alu_op_oh_b;
  logic        alu_com_result_b;
  logic [5:0]  fcsr_flags_b;

  // Behavioural ALU environment: computes from whatever strobes/operands the DUT drives.
  function automatic logic [32:0] alu_fn(input logic [9:0] oh, input logic [31:0] x,
                                         input logic [31:0] y);
    logic [31:0] r;
    logic        c;
    r = '0;
    c = 1'b0;
    if (oh[0]) r = x + y;
    else if (oh[1]) r = x - y;
    else if (oh[2]) r = x * y;
    else if (oh[3]) r = (y == 0) ? 32'd0 : x / y;
    else if (oh[4]) r = ~x;
    else if (oh[5]) r = x[31] ? -x : x;
    if (oh[7]) c = (x < y);
    else if (oh[8]) c = (x == y);
    else if (oh[9]) c = (x > y);
    return {c, r};
  endfunction

  assign {alu_com_result, alu_result}     = alu_fn(alu_op_oh, alu_operand1, alu_operand2);
  assign {alu_com_result_b, alu_result_b} = alu_fn(alu_op_oh_b, alu_operand1_b, alu_operand2_b);

  fpu_issue_ctrl #(.ALU_LAT(LatA), .W(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_op         (req_op),
    .req_br         (req_br),
    .req_a          (req_a),
    .req_b          (req_b),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_result     (rsp_result),
    .rsp_taken      (rsp_taken),
    .rsp_illegal    (rsp_illegal),
    .alu_operand1   (alu_operand1),
    .alu_operand2   (alu_operand2),
    .alu_op_oh      (alu_op_oh),
    .alu_result     (alu_result),
    .alu_com_result (alu_com_result),
    .alu_flags      (alu_flags),
    .fcsr_flags     (fcsr_flags),
    .fcsr_clr       (fcsr_clr)
  );

  fpu_issue_ctrl #(.ALU_LAT(LatB), .W(32)) dut_b (
    .clk            (clk),
    .rst_n          (rst_n_b),
    .req_valid      (req_valid_b),
    .req_ready      (req_ready_b),
    .req_op         (req_op),
    .req_br         (req_br),
    .req_a          (req_a),
    .req_b          (req_b),
    .rsp_valid      (rsp_valid_b),
    .rsp_ready      (rsp_ready_b),
    .rsp_result     (rsp_result_b),
    .rsp_taken      (rsp_taken_b),
    .rsp_illegal    (rsp_illegal_b),
    .alu_operand1   (alu_operand1_b),
    .alu_operand2   (alu_operand2_b),
    .alu_op_oh      (alu_op_oh_b),
    .alu_result     (alu_result_b),
    .alu_com_result (alu_com_result_b),
    .alu_flags      (alu_flags),
    .fcsr_flags     (fcsr_flags_b),
    .fcsr_clr       (fcsr_clr)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference model: expected response fields from the request alone.
  function automatic vec_t model(input vec_t v, inout logic [5:0] fcsr);
    vec_t e;
    bit   legal;
    e     = v;
    legal = (v.op <= 4'd6);
    case (v.op)
      4'd0:    e.exp_res = v.a + v.b;
      4'd1:    e.exp_res = v.a - v.b;
      4'd2:    e.exp_res = v.a * v.b;
      4'd3:    e.exp_res = (v.b == 0) ? 32'd0 : v.a / v.b;
      4'd4:    e.exp_res = ~v.a;
      4'd5:    e.exp_res = ($signed(v.a) < 0) ? 32'd0 - v.a : v.a;
      default: e.exp_res = 32'd0;
    endcase
    e.exp_taken = 1'b0;
    if (v.op == 4'd6 && v.br == 2'd1) e.exp_taken = (v.a < v.b);
    if (v.op == 4'd6 && v.br == 2'd2) e.exp_taken = (v.a == v.b);
    if (v.op == 4'd6 && v.br == 2'd3) e.exp_taken = (v.a > v.b);
    e.exp_ill = !legal;
    e.exp_oh  = '0;
    if (legal) e.exp_oh = 10'd1 << v.op;
    if (v.op == 4'd6 && v.br != 2'd0) e.exp_oh = e.exp_oh | (10'd1 << (6 + v.br));
    if (v.pre_clr) fcsr = '0;
    if (legal) fcsr = v.clr_cap ? v.flags : (fcsr | v.flags);
    e.exp_fcsr = fcsr;
    return e;
  endfunction

  // One complete transaction on instance A, compared against v's expected fields.
  task automatic run_txn(input vec_t v);
    int  k;
    int  exp_lat;
    bit  drive_bad;
    bit  hold_bad;
    if (v.pre_clr) begin
      fcsr_clr = 1'b1;
      step();
      fcsr_clr = 1'b0;
      chk("fcsr_clear", fcsr_flags, 6'd0);
    end
    chk("req_ready_idle", req_ready, 1'b1);
    req_valid = 1'b1;
    req_op    = v.op;
    req_br    = v.br;
    req_a     = v.a;
    req_b     = v.b;
    alu_flags = v.flags;
    step();
    req_valid = 1'b0;
    req_a     = $urandom;
    req_b     = $urandom;
    exp_lat   = v.exp_ill ? 2 : 2 + int'(LatA);
    k         = 1;
    drive_bad = 1'b0;
    while (!rsp_valid && k < 40) begin
      if (alu_op_oh !== v.exp_oh || req_ready !== 1'b0) drive_bad = 1'b1;
      if (!v.exp_ill && (alu_operand1 !== v.a || alu_operand2 !== v.b)) drive_bad = 1'b1;
      if (v.clr_cap && k == 1 + int'(LatA)) fcsr_clr = 1'b1;
      step();
      fcsr_clr = 1'b0;
      k++;
    end
    chk("rsp_latency", k, exp_lat);
    chk("alu_drive", drive_bad, 1'b0);
    chk("rsp_result", rsp_result, v.exp_res);
    chk("rsp_taken", rsp_taken, v.exp_taken);
    chk("rsp_illegal", rsp_illegal, v.exp_ill);
    chk("fcsr_flags", fcsr_flags, v.exp_fcsr);
    hold_bad = 1'b0;
    for (int h = 0; h < v.hold; h++) begin
      step();
      if (rsp_valid !== 1'b1 || rsp_result !== v.exp_res || rsp_taken !== v.exp_taken ||
          rsp_illegal !== v.exp_ill || req_ready !== 1'b0 || alu_op_oh !== 10'd0)
        hold_bad = 1'b1;
    end
    if (v.hold > 0) chk("rsp_hold_stable", hold_bad, 1'b0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("rsp_release", {rsp_valid, req_ready, alu_op_oh}, {1'b0, 1'b1, 10'd0});
  endtask

  vec_t        tbl[11];
  vec_t        v;
  logic [5:0]  ref_fcsr;
  int          k;
  bit          bad;

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    //         op     br     a             b       flags  hold clr pre res           tk ill oh       fcsr
    tbl[0]  = '{4'd0, 2'd0, 32'd3,        32'd4,  6'h00, 0, 1'b0, 1'b0, 32'd7,        1'b0, 1'b0, 10'h001, 6'h00};
    tbl[1]  = '{4'd6, 2'd1, 32'd1,        32'd2,  6'h00, 1, 1'b0, 1'b0, 32'd0,        1'b1, 1'b0, 10'h0C0, 6'h00};
    tbl[2]  = '{4'd3, 2'd0, 32'd20,       32'd4,  6'h20, 0, 1'b0, 1'b0, 32'd5,        1'b0, 1'b0, 10'h008, 6'h20};
    tbl[3]  = '{4'd2, 2'd0, 32'd6,        32'd7,  6'h04, 0, 1'b0, 1'b0, 32'd42,       1'b0, 1'b0, 10'h004, 6'h24};
    tbl[4]  = '{4'd9, 2'd2, 32'd5,        32'd6,  6'h3F, 2, 1'b0, 1'b1, 32'd0,        1'b0, 1'b1, 10'h000, 6'h00};
    tbl[5]  = '{4'd1, 2'd3, 32'd10,       32'd3,  6'h02, 0, 1'b0, 1'b0, 32'd7,        1'b0, 1'b0, 10'h002, 6'h02};
    tbl[6]  = '{4'd6, 2'd2, 32'd9,        32'd9,  6'h01, 5, 1'b1, 1'b0, 32'd0,        1'b1, 1'b0, 10'h140, 6'h01};
    tbl[7]  = '{4'd6, 2'd3, 32'd2,        32'd9,  6'h00, 0, 1'b0, 1'b0, 32'd0,        1'b0, 1'b0, 10'h240, 6'h01};
    tbl[8]  = '{4'd4, 2'd0, 32'h000000FF, 32'd0,  6'h00, 0, 1'b0, 1'b0, 32'hFFFFFF00, 1'b0, 1'b0, 10'h010, 6'h01};
    tbl[9]  = '{4'd5, 2'd0, 32'hFFFFFFFB, 32'd0,  6'h08, 0, 1'b0, 1'b0, 32'd5,        1'b0, 1'b0, 10'h020, 6'h09};
    tbl[10] = '{4'd6, 2'd0, 32'd1,        32'd2,  6'h00, 0, 1'b0, 1'b0, 32'd0,        1'b0, 1'b0, 10'h040, 6'h09};

    rst_n       = 1'b0;
    rst_n_b     = 1'b0;
    req_valid   = 1'b0;
    req_valid_b = 1'b0;
    rsp_ready   = 1'b0;
    rsp_ready_b = 1'b0;
    req_op      = '0;
    req_br      = '0;
    req_a       = '0;
    req_b       = '0;
    alu_flags   = '0;
    fcsr_clr    = 1'b0;
    repeat (3) step();
    rst_n   = 1'b1;
    rst_n_b = 1'b1;
    step();
    chk("reset_ready", req_ready, 1'b1);
    chk("reset_rsp", {rsp_valid, rsp_taken, rsp_illegal}, 3'b000);
    chk("reset_result", rsp_result, 32'd0);
    chk("reset_oh", alu_op_oh, 10'd0);
    chk("reset_operands", {alu_operand1, alu_operand2}, 64'd0);
    chk("reset_fcsr", fcsr_flags, 6'd0);

    // Directed vectors
    for (int i = 0; i < 11; i++) run_txn(tbl[i]);

    // Randomized transactions against the reference model
    ref_fcsr = tbl[10].exp_fcsr;
    for (int i = 0; i < 60; i++) begin
      v.op      = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(7, 15)) : 4'($urandom_range(0, 6));
      v.br      = 2'($urandom);
      v.a       = $urandom;
      v.b       = ($urandom_range(0, 3) == 0) ? v.a : $urandom;
      if ($urandom_range(0, 3) == 0) v.a = {$urandom} % 64;
      v.flags   = 6'($urandom);
      v.hold    = int'($urandom_range(0, 3));
      v.clr_cap = (v.op <= 4'd6) && ($urandom_range(0, 7) == 0);
      v.pre_clr = ($urandom_range(0, 9) == 0);
      v         = model(v, ref_fcsr);
      run_txn(v);
    end

    // ALU_LAT=3 instance: latency, then reset while in WAIT
    req_op      = 4'd0;
    req_br      = 2'd0;
    req_a       = 32'd100;
    req_b       = 32'd23;
    req_valid_b = 1'b1;
    step();
    req_valid_b = 1'b0;
    k = 1;
    while (!rsp_valid_b && k < 40) begin
      step();
      k++;
    end
    chk("b_latency", k, 2 + int'(LatB));
    chk("b_result", rsp_result_b, 32'd123);
    rsp_ready_b = 1'b1;
    step();
    rsp_ready_b = 1'b0;

    req_valid_b = 1'b1;
    step();
    req_valid_b = 1'b0;
    step();
    step();
    chk("b_wait_oh", alu_op_oh_b, 10'h001);
    rst_n_b = 1'b0;
    step();
    rst_n_b = 1'b1;
    chk("b_reset_idle", {req_ready_b, rsp_valid_b}, 2'b10);
    chk("b_reset_oh", alu_op_oh_b, 10'd0);
    bad = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (rsp_valid_b !== 1'b0 || alu_op_oh_b !== 10'd0) bad = 1'b1;
    end
    chk("b_no_response", bad, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
